// File: rtl/ipv4_udp_tx_gen.sv
// ipv4_udp_tx_gen: buffers one payload and streams it to the MAC FIFO behind IPv4/UDP headers, padded to 46 bytes.
// Define IPV4_UDP_TX_GEN_UDP_CSUM_EN to compute the UDP checksum; otherwise it is sent as zero.
module ipv4_udp_tx_gen #(
  parameter int          pADDR_W   = 9,
  parameter logic [31:0] pSRC_IP   = 32'hC0A8010A,
  parameter logic [31:0] pDST_IP   = 32'hC0A801FF,
  parameter logic [15:0] pSRC_PORT = 16'h04D2,
  parameter logic [15:0] pDST_PORT = 16'h1389,
  parameter logic [7:0]  pTTL      = 8'h40
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Usr_Byte,
  input  logic       Usr_Byte_Valid,
  input  logic       Usr_Last,
  output logic       Usr_Rdy,
  input  logic       Tx_Idle,
  output logic [7:0] Eth_Byte,
  output logic       Eth_Byte_Valid,
  output logic       Eth_Pkt_Rdy,
  output logic       Busy
);
  typedef logic [pADDR_W:0] cnt_t;
  typedef enum logic [2:0] {IDLE, CSUM, WAIT_TX, HDR, PAYLOAD, PAD, DONE} state_t;
  localparam cnt_t FULL     = {1'b1, {pADDR_W{1'b0}}};
  localparam cnt_t ONE      = cnt_t'(1);
  localparam cnt_t IP_WORDS = cnt_t'(10);
  localparam cnt_t HDR_LAST = cnt_t'(27);
  localparam cnt_t PAD_LAST = cnt_t'(17);
  localparam cnt_t MIN_LEN  = cnt_t'(18);
`ifdef IPV4_UDP_TX_GEN_UDP_CSUM_EN
  localparam cnt_t CSUM_LAST = cnt_t'(17);
`else
  localparam cnt_t CSUM_LAST = cnt_t'(9);
`endif
  state_t      state_q;
  logic [7:0]  mem [2**pADDR_W];
  cnt_t        len_q, cnt_q;
  logic [15:0] ident_q;
  logic [19:0] ip_acc_q;
  logic        usr_rdy_q, valid_q, pkt_rdy_q, busy_q;
  logic [7:0]  byte_q;
  logic        acc_byte;
  logic [15:0] tot_len, udp_len, hdr_csum, udp_csum, fold2;
  logic [16:0] fold1;
  logic [15:0] ip_w [10];
  logic [223:0] hdr;
  logic [4:0]  hsel;
  assign acc_byte = usr_rdy_q && Usr_Byte_Valid;
  assign tot_len  = 16'(len_q) + 16'd28;
  assign udp_len  = 16'(len_q) + 16'd8;
  assign fold1    = {1'b0, ip_acc_q[15:0]} + 17'(ip_acc_q[19:16]);
  assign fold2    = fold1[15:0] + 16'(fold1[16]);
  assign hdr_csum = ~fold2;
  assign ip_w = '{16'h4500, tot_len, ident_q, 16'h4000, {pTTL, 8'h11}, 16'h0000,
                  pSRC_IP[31:16], pSRC_IP[15:0], pDST_IP[31:16], pDST_IP[15:0]};
  assign hdr = {16'h4500, tot_len, ident_q, 16'h4000, pTTL, 8'h11, hdr_csum, pSRC_IP, pDST_IP,
                pSRC_PORT, pDST_PORT, udp_len, udp_csum};
  assign hsel = 5'd27 - cnt_q[4:0];
`ifdef IPV4_UDP_TX_GEN_UDP_CSUM_EN
  logic [15:0] udp_acc_q, udp_add, hi_q;
  logic [15:0] udp_w [8];
  // UdpLen appears in both pseudo-header and UDP header, so it is added once doubled
  assign udp_w = '{pSRC_IP[31:16], pSRC_IP[15:0], pDST_IP[31:16], pDST_IP[15:0], 16'h0011,
                   {udp_len[14:0], 1'b0}, pSRC_PORT, pDST_PORT};
  assign udp_add = state_q == CSUM ? udp_w[cnt_q[2:0] - 3'd2] :
                   len_q[0] ? {hi_q, Usr_Byte} : {Usr_Byte, 8'h00};
  assign udp_csum = udp_acc_q == 16'hFFFF ? 16'hFFFF : ~udp_acc_q;
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction
  always_ff @(posedge Clk) begin
    if (acc_byte) hi_q <= Usr_Byte;
    if (Rst || state_q == DONE) udp_acc_q <= '0;
    else if ((state_q == CSUM && cnt_q >= IP_WORDS) || (acc_byte && (len_q[0] || Usr_Last)))
      udp_acc_q <= oc_add(udp_acc_q, udp_add);
  end
`else
  assign udp_csum = 16'h0000;
`endif
  always_ff @(posedge Clk)
    if (acc_byte) mem[len_q[pADDR_W-1:0]] <= Usr_Byte;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      ident_q   <= '0;
      ip_acc_q  <= '0;
      usr_rdy_q <= 1'b0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      pkt_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      busy_q    <= state_q != IDLE;
      valid_q   <= 1'b0;
      pkt_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          usr_rdy_q <= len_q != FULL;
          if (acc_byte) begin
            len_q     <= len_q + ONE;
            cnt_q     <= '0;
            usr_rdy_q <= !Usr_Last && (len_q + ONE != FULL);
            if (Usr_Last) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (cnt_q < IP_WORDS) ip_acc_q <= ip_acc_q + 20'(ip_w[cnt_q[3:0]]);
          cnt_q <= cnt_q + ONE;
          if (cnt_q == CSUM_LAST) state_q <= WAIT_TX;
        end
        WAIT_TX: begin
          cnt_q <= '0;
          if (Tx_Idle) state_q <= HDR;
        end
        HDR: begin
          valid_q <= 1'b1;
          byte_q  <= hdr[{hsel, 3'b000} +: 8];
          cnt_q   <= cnt_q == HDR_LAST ? '0 : cnt_q + ONE;
          if (cnt_q == HDR_LAST) state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          valid_q <= 1'b1;
          byte_q  <= mem[cnt_q[pADDR_W-1:0]];
          cnt_q   <= cnt_q + ONE;
          if (cnt_q == len_q - ONE) state_q <= len_q < MIN_LEN ? PAD : DONE;
        end
        PAD: begin
          valid_q <= 1'b1;
          byte_q  <= 8'h00;
          cnt_q   <= cnt_q + ONE;
          if (cnt_q == PAD_LAST) state_q <= DONE;
        end
        DONE: begin
          pkt_rdy_q <= 1'b1;
          ident_q   <= ident_q + 16'd1;
          len_q     <= '0;
          ip_acc_q  <= '0;
          usr_rdy_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Usr_Rdy        = usr_rdy_q;
  assign Eth_Byte       = byte_q;
  assign Eth_Byte_Valid = valid_q;
  assign Eth_Pkt_Rdy    = pkt_rdy_q;
  assign Busy           = busy_q;
endmodule

// File: tb/tb_ipv4_udp_tx_gen.sv
// tb_ipv4_udp_tx_gen: randomized payloads checked against an arithmetic IPv4/UDP frame model.
module tb_ipv4_udp_tx_gen;
  localparam logic [31:0] SRC_IP = 32'hC0A8010A;
  localparam logic [31:0] DST_IP = 32'hC0A801FF;
  localparam logic [15:0] SPORT  = 16'h04D2;
  localparam logic [15:0] DPORT  = 16'h1389;
  localparam logic [7:0]  TTL    = 8'h40;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [7:0] Usr_Byte = 8'h00;
  logic Usr_Byte_Valid = 1'b0, Usr_Last = 1'b0, Tx_Idle = 1'b1;
  logic Usr_Rdy, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy;
  logic [7:0] Eth_Byte;
  int total = 0, bad = 0, cyc = 0, last_valid_cyc = 0, starts = 0, pulses = 0, exp_id = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got[$], exp_q[$], pay[$];

  ipv4_udp_tx_gen dut (
    .Clk(Clk), .Rst(Rst), .Usr_Byte(Usr_Byte), .Usr_Byte_Valid(Usr_Byte_Valid),
    .Usr_Last(Usr_Last), .Usr_Rdy(Usr_Rdy), .Tx_Idle(Tx_Idle), .Eth_Byte(Eth_Byte),
    .Eth_Byte_Valid(Eth_Byte_Valid), .Eth_Pkt_Rdy(Eth_Pkt_Rdy), .Busy(Busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Eth_Byte_Valid) begin
      got.push_back(Eth_Byte);
      last_valid_cyc = cyc;
      if (!prev_valid) starts++;
    end
    if (Eth_Pkt_Rdy) pulses++;
    prev_valid = Eth_Byte_Valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push16(input logic [15:0] v);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endfunction

  function automatic logic [15:0] fold(input int s);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction

  // Expected frame payload for the current pay[] and a given identification value
  function automatic void build(input int id);
    int n, s;
    logic [15:0] tot, ul, ipc, uc;
    n   = pay.size();
    tot = 16'(n + 28);
    ul  = 16'(n + 8);
    uc  = 16'h0000;
    s = 32'h4500 + int'(tot) + (id & 32'hFFFF) + 32'h4000 + int'({TTL, 8'h11})
      + int'(SRC_IP[31:16]) + int'(SRC_IP[15:0]) + int'(DST_IP[31:16]) + int'(DST_IP[15:0]);
    ipc = ~fold(s);
`ifdef IPV4_UDP_TX_GEN_UDP_CSUM_EN
    s = int'(SRC_IP[31:16]) + int'(SRC_IP[15:0]) + int'(DST_IP[31:16]) + int'(DST_IP[15:0])
      + 17 + int'(ul) + int'(SPORT) + int'(DPORT) + int'(ul);
    for (int i = 0; i < n; i += 2) s += int'({pay[i], (i + 1 < n) ? pay[i+1] : 8'h00});
    uc = ~fold(s);
    if (uc == 16'h0000) uc = 16'hFFFF;
`endif
    exp_q = {};
    push16(16'h4500); push16(tot); push16(16'(id)); push16(16'h4000); push16({TTL, 8'h11});
    push16(ipc); push16(SRC_IP[31:16]); push16(SRC_IP[15:0]); push16(DST_IP[31:16]);
    push16(DST_IP[15:0]); push16(SPORT); push16(DPORT); push16(ul); push16(uc);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    while (exp_q.size() < 46) exp_q.push_back(8'h00);
  endfunction

  task automatic send_payload(input bit junk);
    for (int i = 0; i < pay.size(); i++) begin
      int t = 0;
      Usr_Byte = pay[i];
      Usr_Byte_Valid = 1'b1;
      Usr_Last = (i == pay.size() - 1);
      while (!Usr_Rdy && t < 1000) begin @(negedge Clk); t++; end
      if (t >= 1000) begin
        total++; bad++;
        $display("FAIL usr_rdy_timeout: byte %0d not accepted, Usr_Rdy=%b want 1", i, Usr_Rdy);
        break;
      end
      @(negedge Clk);
    end
    Usr_Byte = 8'($urandom);
    Usr_Byte_Valid = junk;
    Usr_Last = junk & 1'($urandom);
  endtask

  task automatic check_pkt(input int base, input int st0, input string name);
    int t = 0, n, mism = -1;
    while (!Eth_Pkt_Rdy && t < 3000) begin @(negedge Clk); t++; end
    total++;
    if (Eth_Pkt_Rdy !== 1'b1) begin
      bad++;
      $display("FAIL %s pkt_rdy: Eth_Pkt_Rdy=%b after 3000 cycles, want 1", name, Eth_Pkt_Rdy);
      return;
    end
    build(exp_id);
    n = got.size() - base;
    total++;
    if (n != exp_q.size()) begin
      bad++; $display("FAIL %s length: got %0d bytes want %0d", name, n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (got[base+i] !== exp_q[i]) begin mism = i; break; end
    total++;
    if (mism >= 0) begin
      bad++;
      $display("FAIL %s byte %0d: got %02h want %02h", name, mism, got[base+mism], exp_q[mism]);
    end
    total++;
    if (n < 6 || {got[base+4], got[base+5]} !== 16'(exp_id)) begin
      bad++; $display("FAIL %s ident: got %04h want %04h", name,
                      n < 6 ? 16'hxxxx : {got[base+4], got[base+5]}, 16'(exp_id));
    end
    total++;
    if (cyc - last_valid_cyc != 1) begin
      bad++; $display("FAIL %s pkt_rdy_gap: got %0d cycles want 1", name, cyc - last_valid_cyc);
    end
    total++;
    if (starts - st0 != 1) begin
      bad++; $display("FAIL %s contiguity: got %0d valid bursts want 1", name, starts - st0);
    end
    exp_id++;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Usr_Byte_Valid = 1'b0; Usr_Last = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0; exp_id = 0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    total++;
    if ({Usr_Rdy, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy} !== 4'b0000 || Eth_Byte !== 8'h00) begin
      bad++; $display("FAIL reset_values: rdy/vld/pkt/busy=%b byte=%02h want 0000 00",
                      {Usr_Rdy, Eth_Byte_Valid, Eth_Pkt_Rdy, Busy}, Eth_Byte);
    end
    Rst = 1'b0; exp_id = 0;
    @(negedge Clk);
    total++;
    if (Busy !== 1'b0 || Eth_Byte_Valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: busy=%b vld=%b want 0 0", Busy, Eth_Byte_Valid);
    end
  endtask

  task automatic test_basic();
    int base = got.size(), st0 = starts;
    pay = {};
    for (int i = 0; i < 18; i++) pay.push_back(8'(i));
    Tx_Idle = 1'b1;
    send_payload(1'b0);
    check_pkt(base, st0, "basic");
    total++;
    if ({got[base+10], got[base+11]} !== 16'hB665) begin
      bad++; $display("FAIL basic_hdr_csum: got %02h%02h want b665", got[base+10], got[base+11]);
    end
    total++;
    if ({got[base+2], got[base+3], got[base+24], got[base+25]} !== 32'h002E001A) begin
      bad++; $display("FAIL basic_lengths: got %02h%02h %02h%02h want 002e 001a",
                      got[base+2], got[base+3], got[base+24], got[base+25]);
    end
    @(negedge Clk);
    total++;
    if (Eth_Pkt_Rdy !== 1'b0 || Busy !== 1'b0) begin
      bad++; $display("FAIL basic_pulse_width: pkt=%b busy=%b want 0 0", Eth_Pkt_Rdy, Busy);
    end
  endtask

  task automatic test_pad();
    int base = got.size(), st0 = starts;
    pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_payload(1'b0);
    check_pkt(base, st0, "pad");
    total++;
    if ({got[base+2], got[base+3], got[base+24], got[base+25]} !== 32'h0020000C) begin
      bad++; $display("FAIL pad_lengths: got %02h%02h %02h%02h want 0020 000c",
                      got[base+2], got[base+3], got[base+24], got[base+25]);
    end
  endtask

  task automatic test_wait();
    int base = got.size(), st0 = starts;
    bit held = 1'b1, seen = 1'b0;
    pay = {};
    repeat (10) pay.push_back(8'($urandom));
    Tx_Idle = 1'b0;
    send_payload(1'b0);
    repeat (2) @(negedge Clk);
    repeat (50) begin
      if (Eth_Byte_Valid !== 1'b0 || Busy !== 1'b1) held = 1'b0;
      @(negedge Clk);
    end
    total++;
    if (!held) begin
      bad++; $display("FAIL wait_hold: vld=%b busy=%b while Tx_Idle=0, want 0 1", Eth_Byte_Valid, Busy);
    end
    Tx_Idle = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      if (Eth_Byte_Valid === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL wait_release: vld=%b 2 cycles after Tx_Idle rose, want 1", Eth_Byte_Valid);
    end
    check_pkt(base, st0, "wait");
  endtask

  task automatic test_max();
    int base = got.size(), st0 = starts;
    pay = {};
    repeat (512) pay.push_back(8'($urandom));
    send_payload(1'b0);
    total++;
    if (Usr_Rdy !== 1'b0) begin
      bad++; $display("FAIL max_rdy_drop: Usr_Rdy=%b after byte 512, want 0", Usr_Rdy);
    end
    check_pkt(base, st0, "max");
    total++;
    if ({got[base+2], got[base+3]} !== 16'h021C) begin
      bad++; $display("FAIL max_totlen: got %02h%02h want 021c", got[base+2], got[base+3]);
    end
  endtask

  task automatic test_rst_mid();
    int base = got.size(), st0, t = 0, n, g, p0;
    pay = {};
    repeat (20) pay.push_back(8'($urandom));
    send_payload(1'b0);
    while (got.size() < base + 38 && t < 500) begin @(posedge Clk); t++; end
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    total++;
    if (Eth_Byte_Valid !== 1'b0 || Busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid_abort: vld=%b busy=%b want 0 0", Eth_Byte_Valid, Busy);
    end
    n = got.size() - base;
    total++;
    if (n < 38 || n > 40) begin
      bad++; $display("FAIL rst_mid_position: got %0d bytes before abort want 38..40", n);
    end
    Rst = 1'b0; exp_id = 0;
    g = got.size(); p0 = pulses;
    repeat (30) @(negedge Clk);
    total++;
    if (pulses != p0 || got.size() != g) begin
      bad++; $display("FAIL rst_mid_quiet: got %0d pulses %0d bytes want 0 0", pulses - p0, got.size() - g);
    end
    base = got.size(); st0 = starts;
    pay = {};
    repeat (12) pay.push_back(8'($urandom));
    send_payload(1'b0);
    check_pkt(base, st0, "after_rst");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      int base = got.size(), st0 = starts;
      pay = {};
      repeat ($urandom_range(1, 40)) pay.push_back(8'($urandom));
      send_payload(1'b1);
      check_pkt(base, st0, $sformatf("b2b%0d", k));
    end
    Usr_Byte_Valid = 1'b0; Usr_Last = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_wait();
    test_max();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ipv4_udp_tx_gen.md
Name: ipv4_udp_tx_gen

Overview:
- Upstream packet builder for the Ethernet RMII transmit path.
- Buffers one user payload, then prepends a 20-byte IPv4 header and an 8-byte UDP header, and pads the IP payload to the 46-byte Ethernet minimum.
- Streams bytes into the MAC transmitter's payload FIFO, then pulses Eth_Pkt_Rdy to launch the frame.
- The MAC stage adds preamble, SFD, MAC addresses, type 0x0800 and FCS.

Parameters:
pADDR_W, 9, log2 of payload buffer depth; maximum payload is 2^pADDR_W bytes (512)
pSRC_IP, 32'hC0A8010A, IPv4 source address
pDST_IP, 32'hC0A801FF, IPv4 destination address
pSRC_PORT, 16'h04D2, UDP source port
pDST_PORT, 16'h1389, UDP destination port
pTTL, 8'h40, IPv4 time-to-live

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
Usr_Byte  in  8  payload byte
Usr_Byte_Valid  in  1  payload byte strobe; accepted when Usr_Rdy=1
Usr_Last  in  1  qualifies the accepted byte as the last byte of the payload
Usr_Rdy  out  1  generator can accept a payload byte
Tx_Idle  in  1  downstream MAC idle (FIFO empty, no frame in flight)
Eth_Byte  out  8  byte to MAC FIFO
Eth_Byte_Valid  out  1  Eth_Byte write strobe
Eth_Pkt_Rdy  out  1  one-cycle pulse: frame payload fully written
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: Usr_Rdy=0, Eth_Byte=0, Eth_Byte_Valid=0, Eth_Pkt_Rdy=0, Busy=0.
- Reset also clears the payload count, the identification counter (Ident) and the checksum accumulator.
- Reset asserted mid-packet abandons the packet immediately. The next cycle after reset deassertion is IDLE with an empty buffer.
- States: IDLE -> CSUM -> WAIT_TX -> HDR -> PAYLOAD -> PAD -> DONE -> IDLE.
- IDLE:
  - Usr_Rdy=1 unless the buffer holds 2^pADDR_W bytes.
  - Each accepted byte is written at address Len; Len increments.
  - An accepted byte with Usr_Last=1 moves to CSUM.
  - Usr_Last on a byte that is not accepted is ignored.
  - At full buffer, Usr_Rdy=0 until Usr_Last. A full buffer without Usr_Last holds; the user must supply Last on the final accepted byte.
- CSUM:
  - 10 cycles; one 16-bit header word per cycle is added into a 20-bit accumulator.
  - Words, in order: 16'h4500, TotLen, Ident, 16'h4000 (DF set), {pTTL,8'h11}, 16'h0000, SrcIP[31:16], SrcIP[15:0], DstIP[31:16], DstIP[15:0].
  - TotLen = Len+28. UdpLen = Len+8.
  - On exit: fold carries twice (sum[15:0]+sum[19:16]); HdrCsum = ~folded.
- WAIT_TX: hold until Tx_Idle=1. Tx_Idle already high still costs exactly one cycle in this state.
- HDR:
  - 28 consecutive cycles with Eth_Byte_Valid=1, bytes in network order (MSB byte first).
  - Byte order: 45 00 TotLen[15:8] TotLen[7:0] Ident[15:8] Ident[7:0] 40 00 pTTL 11 HdrCsum(2) SrcIP(4) DstIP(4) SrcPort(2) DstPort(2) UdpLen(2) UdpCsum(2).
- PAYLOAD:
  - Len consecutive valid bytes read from the buffer (address 0 first).
  - There is no gap between the last HDR byte and the first payload byte. The buffer read latency is hidden by prefetch.
- PAD: if Len<18, emit 18-Len bytes of 8'h00; otherwise skip. TotLen and UdpLen exclude padding.
- DONE:
  - Eth_Byte_Valid=0, Eth_Pkt_Rdy=1 for exactly one cycle. This is the cycle after the last valid byte.
  - Ident increments (wraps 16'hFFFF -> 0). Len clears. Return to IDLE.
- Eth_Byte holds its last value when Eth_Byte_Valid=0.
- Usr_Byte_Valid outside IDLE is ignored (Usr_Rdy=0).
- Tx_Idle is sampled only in WAIT_TX.

Optional Feature:
- Macro: IPV4_UDP_TX_GEN_UDP_CSUM_EN.
- Defined:
  - UDP checksum is accumulated during ingest: payload bytes are paired MSB-first, and an odd final byte is padded with 8'h00.
  - In CSUM, additional words are added: the pseudo-header (SrcIP, DstIP, 16'h0011, UdpLen) and the UDP header (ports, UdpLen, 0). This adds 8 cycles to CSUM.
  - After folding, UdpCsum = ~folded; a result of 16'h0000 is sent as 16'hFFFF.
- Undefined: UdpCsum=16'h0000 (checksum disabled per IPv4 UDP), and the UDP accumulator logic is absent.

Test Plan:
- Reset then 18-byte payload 0x00..0x11 with Tx_Idle=1 -> 46 valid bytes: 45 00 00 2E 00 00 40 00 40 11 B6 65 C0 A8 01 0A C0 A8 01 FF 04 D2 13 89 00 1A 00 00 00..11. Eth_Pkt_Rdy pulses the next cycle; no PAD bytes.
- 4-byte payload AA BB CC DD -> TotLen 0x0020, UdpLen 0x000C. Emits 28 header + 4 payload + 14 bytes 0x00 (46 total). Ident=1 if run after the first test.
- Hold Tx_Idle=0 for 50 cycles after Usr_Last -> Eth_Byte_Valid stays 0 and Busy=1. First header byte appears within 2 cycles of Tx_Idle rising.
- 512-byte payload -> Usr_Rdy drops after byte 512, which carries Usr_Last. 540 contiguous valid bytes; TotLen 0x021C.
- Assert Rst during PAYLOAD byte 10 -> Eth_Byte_Valid=0 the next cycle, no Eth_Pkt_Rdy pulse. Ident=0, and the next packet's header is correct.
- Back-to-back packets -> Ident sequence 0,1,2. Usr_Byte_Valid held high while Busy causes no buffer writes.
